// File: rtl/nibble_deserializer_pkg.sv
// Shared state encodings and width constants for the nibble deserializer.
package nibble_deserializer_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    FULL  = 2'd3
  } state_e;

  // Even parity over four data bits plus the parity bit.
  function automatic logic even_parity_ok(input logic [NIB_W-1:0] nib, input logic par);
    return ~(^{nib, par});
  endfunction

endpackage

// File: rtl/nibble_deserializer_two_bit_counter.sv
// Two-bit accepted-bit counter; wraps 3 -> 0 on increment.
module two_bit_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [1:0] cnt
);

  logic [1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 2'd0;
    end else if (inc) begin
      cnt_q <= cnt_q + 2'd1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/nibble_deserializer.sv
// Serial-to-nibble deserializer with valid/ready on both sides.
// Optional trailing even-parity bit per nibble when NIBBLE_PARITY_CHECK_EN is defined.
//
// state | meaning
// IDLE  | no data bits held
// SHIFT | 1-3 data bits held
// PAR   | 4 data bits held, waiting for parity bit (parity build only)
// FULL  | nibble complete, out_valid high
module nibble_deserializer
  import nibble_deserializer_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic             ser_ready,
  output logic [NIB_W-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             par_err
);

  state_e           state_q, state_d;
  logic [NIB_W-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             armed_q;
  logic [1:0]       cnt;
  logic [1:0]       bit_idx;
  logic             accept;
  logic             xfer;
  logic             data_acc;

  // Ready is held low until the first edge after reset release.
  assign ser_ready = armed_q & ((state_q != FULL) | out_ready);
  assign accept    = ser_valid & ser_ready;
  assign xfer      = out_valid_q & out_ready;
  assign data_acc  = accept & (state_q != PAR);
  assign bit_idx   = MSB_FIRST ? (2'd3 - cnt) : cnt;

  two_bit_counter u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (data_acc),
    .cnt (cnt)
  );

`ifdef NIBBLE_PARITY_CHECK_EN
  logic par_err_q, par_err_d;
  logic par_ok;

  assign par_ok = even_parity_ok(out_q, ser_in);
`endif

  always_comb begin
    state_d = state_q;
`ifdef NIBBLE_PARITY_CHECK_EN
    par_err_d = 1'b0;
`endif
    case (state_q)
      IDLE:  if (accept) state_d = SHIFT;
      SHIFT: begin
        if (accept && (cnt == 2'd3)) begin
`ifdef NIBBLE_PARITY_CHECK_EN
          state_d = PAR;
`else
          state_d = FULL;
`endif
        end
      end
`ifdef NIBBLE_PARITY_CHECK_EN
      PAR: begin
        if (accept) begin
          state_d   = par_ok ? FULL : IDLE;
          par_err_d = ~par_ok;
        end
      end
`endif
      FULL:  if (xfer) state_d = accept ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_d = out_q;
    if (data_acc) out_d[bit_idx] = ser_in;
  end

  assign out_valid_d = (state_d == FULL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      armed_q     <= 1'b1;
    end
  end

`ifdef NIBBLE_PARITY_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_nibble_deserializer.sv
// Bench for nibble_deserializer: MSB-first and LSB-first instances share stimulus.
module tb_nibble_deserializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ser_in = 1'b0, ser_valid = 1'b0, out_ready = 1'b0;
  logic       ready_m, ready_l, ov_m, ov_l, perr_m, perr_l;
  logic [3:0] out_m, out_l;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  nibble_deserializer #(.MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid), .ser_ready(ready_m),
    .out(out_m), .out_valid(ov_m), .out_ready(out_ready), .par_err(perr_m));

  nibble_deserializer #(.MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid), .ser_ready(ready_l),
    .out(out_l), .out_valid(ov_l), .out_ready(out_ready), .par_err(perr_l));

  // Reference model: accepted bits collected in a queue, nibble pending flag.
  bit         m_armed;
  bit         m_pend;
  bit         m_perr;
  bit         m_bits[$];
  logic [3:0] m_nib_m, m_nib_l;

  function automatic bit m_ready(input bit ordy);
    return m_armed && (!m_pend || ordy);
  endfunction

  function automatic void model_reset();
    m_bits.delete();
    m_armed = 0;
    m_pend  = 0;
    m_perr  = 0;
  endfunction

  function automatic void model_step(input bit sv, input bit si, input bit ordy);
    bit acc;
    int ones;
    acc    = sv && m_ready(ordy);
    m_perr = 0;
    if (m_pend && ordy) m_pend = 0;
    if (acc) m_bits.push_back(si);
`ifdef NIBBLE_PARITY_CHECK_EN
    if (m_bits.size() == 5) begin
      ones = 0;
      foreach (m_bits[i]) ones += int'(m_bits[i]);
      if (ones % 2 == 0) begin
        for (int k = 0; k < 4; k++) begin
          m_nib_m[3-k] = m_bits[k];
          m_nib_l[k]   = m_bits[k];
        end
        m_pend = 1;
      end else begin
        m_perr = 1;
      end
      m_bits.delete();
    end
`else
    ones = 0;
    if (m_bits.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        m_nib_m[3-k] = m_bits[k];
        m_nib_l[k]   = m_bits[k];
        ones += int'(m_bits[k]);
      end
      m_pend = 1;
      m_bits.delete();
    end
`endif
    m_armed = 1;
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    else passed++;
  endtask

  // Drive one cycle from a negedge: check model expectations, then advance.
  task automatic cycle(input logic sv, input logic si, input logic ordy);
    ser_valid = sv; ser_in = si; out_ready = ordy;
    #1;
    chk("ready_m", ready_m, m_ready(ordy));
    chk("ready_l", ready_l, m_ready(ordy));
    chk("valid_m", ov_m, m_pend);
    chk("valid_l", ov_l, m_pend);
    if (m_pend) begin
      chk("out_m", out_m, m_nib_m);
      chk("out_l", out_l, m_nib_l);
    end
    chk("par_err_m", perr_m, m_perr);
    chk("par_err_l", perr_l, m_perr);
    model_step(sv, si, ordy);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; ser_valid = 1'b0; ser_in = 1'b0; out_ready = 1'b0;
    #1;
    model_reset();
    chk("rst_ready", {ready_l, ready_m}, 4'b0000);
    chk("rst_valid", {ov_l, ov_m}, 4'b0000);
    chk("rst_out_m", out_m, 4'b0000);
    chk("rst_out_l", out_l, 4'b0000);
    chk("rst_par_err", {perr_l, perr_m}, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_ready", {ready_l, ready_m}, 4'b0000);
    model_step(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic sv, si, ordy, rdy, ov;
    logic [3:0] om, ol;
  } vec_t;

  vec_t tbl[18];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1011, 4'b1101};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 4'b0001};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 4'b0001};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1000, 4'b0001};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1101, 4'b1011};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0};

    model_reset();
    @(negedge clk);
    do_reset();

`ifndef NIBBLE_PARITY_CHECK_EN
    for (int i = 0; i < 18; i++) begin
      ser_valid = tbl[i].sv; ser_in = tbl[i].si; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_ready", i), ready_m, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), ov_m, tbl[i].ov);
      if (tbl[i].ov) begin
        chk($sformatf("tbl%0d_out_m", i), out_m, tbl[i].om);
        chk($sformatf("tbl%0d_out_l", i), out_l, tbl[i].ol);
      end
      cycle(tbl[i].sv, tbl[i].si, tbl[i].ordy);
    end
`else
    // Good parity: 1100 + 0.
    cycle(1, 1, 1); cycle(1, 1, 1); cycle(1, 0, 1); cycle(1, 0, 1); cycle(1, 0, 1);
    out_ready = 1'b1; ser_valid = 1'b0;
    #1;
    chk("par_ok_valid", ov_m, 1'b1);
    chk("par_ok_out_m", out_m, 4'b1100);
    chk("par_ok_out_l", out_l, 4'b0011);
    chk("par_ok_err", perr_m, 1'b0);
    cycle(0, 0, 1);
    // Bad parity: 1000 + 0.
    cycle(1, 1, 1); cycle(1, 0, 1); cycle(1, 0, 1); cycle(1, 0, 1); cycle(1, 0, 1);
    out_ready = 1'b1; ser_valid = 1'b0;
    #1;
    chk("par_bad_err", perr_m, 1'b1);
    chk("par_bad_valid", ov_m, 1'b0);
    cycle(0, 0, 1);
    chk("par_bad_err_pulse", perr_m, 1'b0);
    chk("par_bad_valid2", ov_m, 1'b0);
`endif

    // Reset after two bits discards them.
    cycle(1, 1, 1); cycle(1, 1, 1);
    do_reset();
    cycle(1, 0, 1); cycle(1, 1, 1); cycle(1, 1, 1); cycle(1, 0, 1);
`ifdef NIBBLE_PARITY_CHECK_EN
    cycle(1, 0, 1);
`endif
    ser_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_mid_valid", ov_m, 1'b1);
    chk("rst_mid_out_m", out_m, 4'b0110);
    chk("rst_mid_out_l", out_l, 4'b0110);
    cycle(0, 0, 1);

    // Reset while FULL drops the pending nibble.
    cycle(1, 1, 0); cycle(1, 0, 0); cycle(1, 1, 0); cycle(1, 0, 0);
`ifdef NIBBLE_PARITY_CHECK_EN
    cycle(1, 0, 0);
`endif
    cycle(0, 0, 0);
    do_reset();
    cycle(0, 0, 1);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
              ($urandom_range(0, 2) != 0));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
